// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file and its pending scoreboard.
package reg_file_pkg;

    localparam int unsigned MAX_NREGS = 64;
    localparam int unsigned REG_ZERO  = 0;

    typedef logic [MAX_NREGS-1:0] pend_vec_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input pend_vec_t v);
        int unsigned c = 0;
        for (int unsigned i = 0; i < MAX_NREGS; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: issue marks a destination busy, writeback clears it.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          haz1,
    output logic          haz2,
    output logic [AW:0]   busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [AW:0]      busy_q, busy_d;

    // Clear is applied before set so a new producer issued in the writeback cycle wins.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (we && wa == AW'(r))            pend_d[r] = 1'b0;
            if (iss_valid && iss_rd == AW'(r)) pend_d[r] = 1'b1;
        end
        pend_d[REG_ZERO] = 1'b0;
        busy_d = CW'(popcount(pend_vec_t'(pend_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            busy_q <= '0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

    assign haz1     = pend_q[ra1];
    assign haz2     = pend_q[ra2];
    assign busy_cnt = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// NREGS x WIDTH register file, r0 hardwired to zero, with pending scoreboard.
// Optional write-through forwarding under `REGFILE_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    output logic             haz1,
    output logic             haz2,
    output logic [AW:0]      busy_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic             sb_haz1, sb_haz2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we && wa != ZERO_ADDR) begin
            mem_q[wa] <= wd;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wa        (wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .haz1      (sb_haz1),
        .haz2      (sb_haz2),
        .busy_cnt  (busy_cnt)
    );

    always_comb begin
        rd1  = (ra1 == ZERO_ADDR) ? '0 : mem_q[ra1];
        rd2  = (ra2 == ZERO_ADDR) ? '0 : mem_q[ra2];
        haz1 = sb_haz1;
        haz2 = sb_haz2;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != ZERO_ADDR && wa == ra1) begin
            rd1  = wd;
            haz1 = 1'b0;
        end
        if (we && wa != ZERO_ADDR && wa == ra2) begin
            rd2  = wd;
            haz2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes model expectations, monitor pops and compares.
module tb_reg_file_sb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [AW-1:0]    ra1 = '0, ra2 = '0, wa = '0, iss_rd = '0;
    logic [WIDTH-1:0] wd = '0;
    logic             we = 1'b0, iss_valid = 1'b0;
    logic [WIDTH-1:0] rd1, rd2;
    logic             haz1, haz2;
    logic [AW:0]      busy_cnt;

    reg_file_sb #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .haz1      (haz1),
        .haz2      (haz2),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic             h1;
        logic             h2;
        logic [AW:0]      busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays updated by the architectural rules.
    logic [WIDTH-1:0] m_mem  [NREGS];
    bit               m_pend [NREGS];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned model_busy();
        int unsigned c = 0;
        foreach (m_pend[i]) if (m_pend[i]) c++;
        return c;
    endfunction

    // One cycle: drive inputs after the edge, record what the outputs must show
    // before the next edge, then advance the model across that edge.
    task automatic drive(input bit r, input bit w, input int unsigned a_w, input logic [WIDTH-1:0] d_w,
                         input bit iv, input int unsigned a_i, input int unsigned a1, input int unsigned a2,
                         input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; we = w; wa = AW'(a_w); wd = d_w;
        iss_valid = iv; iss_rd = AW'(a_i); ra1 = AW'(a1); ra2 = AW'(a2);
        if (chk) begin
            e.rd1  = (a1 == 0) ? '0 : m_mem[a1];
            e.rd2  = (a2 == 0) ? '0 : m_mem[a2];
            e.h1   = m_pend[a1];
            e.h2   = m_pend[a2];
            e.busy = (AW+1)'(model_busy());
`ifdef REGFILE_BYPASS_EN
            if (w && a_w != 0 && a_w == a1) begin e.rd1 = d_w; e.h1 = 1'b0; end
            if (w && a_w != 0 && a_w == a2) begin e.rd2 = d_w; e.h2 = 1'b0; end
`endif
            exp_q.push_back(e);
        end
        if (r) begin
            foreach (m_mem[i]) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
        end else begin
            if (w && a_w != 0) begin
                m_mem[a_w]  = d_w;
                m_pend[a_w] = 1'b0;
            end
            if (iv && a_i != 0) m_pend[a_i] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd1", 64'(rd1), 64'(e.rd1));
            check("rd2", 64'(rd2), 64'(e.rd2));
            check("haz1", 64'(haz1), 64'(e.h1));
            check("haz2", 64'(haz2), 64'(e.h2));
            check("busy_cnt", 64'(busy_cnt), 64'(e.busy));
        end
    end

    initial begin
        foreach (m_mem[i]) begin m_mem[i] = '0; m_pend[i] = 1'b0; end

        // Reset, then reset-state reads
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, '0, 0, 0, 5, 31, 1);
        // Writes and issues to r0 are dropped
        drive(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 1);
        drive(0, 0, 0, '0, 0, 0, 0, 0, 1);
        // Issue r7, observe hazard, write back, observe clear
        drive(0, 0, 0, '0, 1, 7, 7, 0, 1);
        drive(0, 1, 7, 32'h1234, 0, 0, 7, 7, 1);
        drive(0, 0, 0, '0, 0, 0, 7, 7, 1);
        // Same-cycle issue and write to a pending register: set wins
        drive(0, 0, 0, '0, 1, 9, 9, 9, 1);
        drive(0, 1, 9, 32'h99, 1, 9, 9, 0, 1);
        drive(0, 0, 0, '0, 0, 0, 9, 9, 1);
        // Write-through on port 2 while r3 pending
        drive(0, 1, 3, 32'h1111, 0, 0, 3, 3, 1);
        drive(0, 0, 0, '0, 1, 3, 0, 3, 1);
        drive(0, 1, 3, 32'hA5A5, 0, 0, 0, 3, 1);
        drive(0, 0, 0, '0, 0, 0, 3, 3, 1);
        // Fill the scoreboard, re-issue a pending reg, then reset with a write in flight
        drive(0, 1, 4, 32'h4444, 0, 0, 4, 0, 1);
        for (int unsigned r = 1; r < NREGS; r++) drive(0, 0, 0, '0, 1, r, r, 4, 1);
        drive(0, 0, 0, '0, 1, 12, 31, 1, 1);
        drive(1, 1, 4, 32'hFFFF, 1, 6, 4, 31, 1);
        drive(0, 0, 0, '0, 0, 0, 4, 6, 1);

        // Randomized traffic, biased toward a small address window to provoke collisions
        for (int unsigned n = 0; n < 600; n++) begin
            int unsigned lim;
            lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
            drive(($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, lim),
                  $urandom,
                  $urandom_range(0, 1),
                  $urandom_range(0, lim),
                  $urandom_range(0, lim),
                  $urandom_range(0, lim),
                  1);
        end
        drive(0, 0, 0, '0, 0, 0, 1, 2, 1);

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
